atomic_unit: RTL and testbench
==============================

ATOMIC_UNIT -- requirements
Module: atomic_unit

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: reset_n  input  1  synchronous, active-low reset.
REQ-003 SHALL have port: is_atomic_mem  input  1  A-extension instruction present in MEM stage.
REQ-004 SHALL have port: fun5_mem  input  5  instr[31:27] op select (LR 00010, SC 00011, SWAP 00001, ADD 00000, XOR 00100, AND 01100, OR 01000, MIN 10000, MAX 10100, MINU 11000, MAXU 11100).
REQ-005 SHALL have ports: addr_mem  input  32  rs1 address; rs2_data_mem  input  32  rs2 operand.
REQ-006 SHALL have port: reservation_clr  input  1  trap/mret/redirect kills reservation.
REQ-007 SHALL have ports: mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_rdata in 32, mem_ack in 1  data-memory handshake.
REQ-008 SHALL have ports: atomic_unit_stall out 1 hold pipeline; atomic_done out 1 result-valid pulse; atomic_result out 32 rd writeback value; atomic_fault out 1 misaligned/illegal pulse.

Function
REQ-009 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-010 IDLE: on is_atomic_mem, latch op/addr/rs2; misaligned (addr[1:0]!=0) or unsupported op -> DONE with fault; LR/AMO -> READ; SC with valid reservation and addr[31:2] match -> WRITE; SC otherwise -> DONE, result 1.
REQ-011 READ: mem_req=1, mem_we=0; on mem_ack capture mem_rdata as old value; LR -> DONE, AMO -> WRITE.
REQ-012 WRITE: mem_req=1, mem_we=1, mem_wdata = AMO(old, rs2) or rs2 for SC; on mem_ack -> DONE.
REQ-013 mem_addr/mem_we/mem_wdata SHALL stay stable while mem_req=1 and mem_ack=0; ack in the first request cycle is legal (zero wait).
REQ-014 DONE: atomic_done=1 for exactly one cycle, atomic_unit_stall=0, then -> IDLE unconditionally.
REQ-015 atomic_unit_stall = is_atomic_mem in IDLE, 1 in READ/WRITE, 0 in DONE (combinational).
REQ-016 atomic_result: LR/AMO = old memory value; SC success 0, SC failure 1; fault 0; held stable in DONE.
REQ-017 MIN/MAX signed 32-bit compare, MINU/MAXU unsigned; ADD wraps modulo 2^32.
REQ-018 Reservation (valid + addr[31:2]) SHALL be set when LR reaches DONE; cleared by any SC reaching DONE, by reservation_clr, by reset.
REQ-019 reservation_clr in same cycle as LR set: clear wins; reservation_clr does not abort an in-flight sequence.
REQ-020 Fault cases SHALL issue no mem_req and assert atomic_fault with atomic_done in DONE.

Reset
REQ-021 reset_n=0 at a rising edge SHALL force IDLE, clear reservation, zero latched operands.
REQ-022 During/after reset: mem_req, mem_we, atomic_done, atomic_fault, atomic_unit_stall = 0; mem_addr, mem_wdata, atomic_result = 0.
REQ-023 Reset mid-READ/WRITE SHALL drop mem_req in the cycle following the reset edge; outstanding ack then ignored.

Configuration
REQ-024 Macro ATOMIC_AMO_EN defined: all AMO ops supported per REQ-010..017.
REQ-025 ATOMIC_AMO_EN undefined: only LR/SC supported; every AMO fun5 takes fault path (REQ-020), ALU logic removed.

Verification
REQ-026 LR 0x100 (mem=0x11), SC 0x100 rs2=0x22 -> LR result 0x11; SC result 0, write 0x22 to 0x100.
REQ-027 SC 0x100 with no prior LR -> result 1, no mem_req, stall 1 cycle then done.
REQ-028 AMOADD 0x200 mem=0xFFFFFFFF rs2=2, ack after 3 wait cycles -> result 0xFFFFFFFF, write 0x00000001, signals stable while waiting.
REQ-029 AMOMIN vs AMOMINU mem=0x80000000 rs2=1 -> writes 0x80000000 and 0x00000001 respectively.
REQ-030 AMOSWAP addr 0x102 -> atomic_fault=1, result 0, no mem_req; reservation_clr same cycle as LR done -> following SC fails (1).
REQ-031 reset_n=0 during WRITE wait -> next cycle mem_req=0, state IDLE, subsequent SC fails.

Source files
------------

// File: rtl/atomic_unit.sv
// rtl/atomic_unit.sv - RV32A LR/SC/AMO sequencer for the MEM stage (AMO ops enabled by ATOMIC_AMO_EN)
module atomic_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        is_atomic_mem,
    input  logic [4:0]  fun5_mem,
    input  logic [31:0] addr_mem,
    input  logic [31:0] rs2_data_mem,
    input  logic        reservation_clr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        atomic_unit_stall,
    output logic        atomic_done,
    output logic [31:0] atomic_result,
    output logic        atomic_fault
);

    localparam logic [4:0] OP_LR   = 5'b00010;
    localparam logic [4:0] OP_SC   = 5'b00011;
    localparam logic [4:0] OP_SWAP = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01100;
    localparam logic [4:0] OP_OR   = 5'b01000;
    localparam logic [4:0] OP_MIN  = 5'b10000;
    localparam logic [4:0] OP_MAX  = 5'b10100;
    localparam logic [4:0] OP_MINU = 5'b11000;
    localparam logic [4:0] OP_MAXU = 5'b11100;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state, state_next;
    logic [4:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] result_q;
    logic        fault_q;
    logic        resv_valid;
    logic [29:0] resv_addr;
    logic        idle_fault;
    logic        sc_hit;

    function automatic logic op_supported(input logic [4:0] op);
        case (op)
            OP_LR, OP_SC: op_supported = 1'b1;
`ifdef ATOMIC_AMO_EN
            OP_SWAP, OP_ADD, OP_XOR, OP_AND, OP_OR,
            OP_MIN, OP_MAX, OP_MINU, OP_MAXU: op_supported = 1'b1;
`endif
            default: op_supported = 1'b0;
        endcase
    endfunction

`ifdef ATOMIC_AMO_EN
    function automatic logic [31:0] amo_calc(input logic [4:0] op, input logic [31:0] old,
                                             input logic [31:0] rs2);
        case (op)
            OP_SWAP: amo_calc = rs2;
            OP_ADD:  amo_calc = old + rs2;
            OP_XOR:  amo_calc = old ^ rs2;
            OP_AND:  amo_calc = old & rs2;
            OP_OR:   amo_calc = old | rs2;
            OP_MIN:  amo_calc = ($signed(old) < $signed(rs2)) ? old : rs2;
            OP_MAX:  amo_calc = ($signed(old) > $signed(rs2)) ? old : rs2;
            OP_MINU: amo_calc = (old < rs2) ? old : rs2;
            OP_MAXU: amo_calc = (old > rs2) ? old : rs2;
            default: amo_calc = old;
        endcase
    endfunction
`endif

    always_comb begin
        state_next = state;
        idle_fault = (addr_mem[1:0] != 2'b00) || !op_supported(fun5_mem);
        sc_hit     = resv_valid && (resv_addr == addr_mem[31:2]);
        case (state)
            IDLE: begin
                if (is_atomic_mem) begin
                    if (idle_fault)
                        state_next = DONE;
                    else if (fun5_mem != OP_SC)
                        state_next = READ;
                    else if (sc_hit)
                        state_next = WRITE;
                    else
                        state_next = DONE;
                end
            end
            READ:    if (mem_ack) state_next = (op_q == OP_LR) ? DONE : WRITE;
            WRITE:   if (mem_ack) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            op_q       <= 5'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            result_q   <= 32'd0;
            fault_q    <= 1'b0;
            resv_valid <= 1'b0;
            resv_addr  <= 30'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (is_atomic_mem) begin
                        op_q     <= fun5_mem;
                        addr_q   <= addr_mem;
                        wdata_q  <= rs2_data_mem;
                        fault_q  <= idle_fault;
                        // Only a failed SC goes straight to DONE with a non-zero result
                        result_q <= (state_next == DONE && !idle_fault) ? 32'd1 : 32'd0;
                    end
                end
                READ: begin
                    if (mem_ack) begin
                        result_q <= mem_rdata;
`ifdef ATOMIC_AMO_EN
                        wdata_q  <= amo_calc(op_q, mem_rdata, wdata_q);
`endif
                    end
                end
                default: ;
            endcase

            // A clear request always beats a concurrent LR setting the reservation
            if (reservation_clr) begin
                resv_valid <= 1'b0;
            end else if (state == DONE && op_q == OP_SC) begin
                resv_valid <= 1'b0;
            end else if (state == DONE && op_q == OP_LR && !fault_q) begin
                resv_valid <= 1'b1;
                resv_addr  <= addr_q[31:2];
            end
        end
    end

    assign mem_req       = (state == READ) || (state == WRITE);
    assign mem_we        = (state == WRITE);
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign atomic_result = result_q;
    assign atomic_done   = (state == DONE);
    assign atomic_fault  = (state == DONE) && fault_q;

    always_comb begin
        case (state)
            IDLE:        atomic_unit_stall = is_atomic_mem;
            READ, WRITE: atomic_unit_stall = 1'b1;
            default:     atomic_unit_stall = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_atomic_unit.sv
// tb/tb_atomic_unit.sv - table-driven and randomized self-checking bench for atomic_unit
module tb_atomic_unit;

    localparam logic [4:0] LR   = 5'b00010;
    localparam logic [4:0] SC   = 5'b00011;
    localparam logic [4:0] SWAP = 5'b00001;
    localparam logic [4:0] ADD  = 5'b00000;
    localparam logic [4:0] XOR_ = 5'b00100;
    localparam logic [4:0] AND_ = 5'b01100;
    localparam logic [4:0] OR_  = 5'b01000;
    localparam logic [4:0] MIN  = 5'b10000;
    localparam logic [4:0] MAX  = 5'b10100;
    localparam logic [4:0] MINU = 5'b11000;
    localparam logic [4:0] MAXU = 5'b11100;
`ifdef ATOMIC_AMO_EN
    localparam bit AMO_ON = 1'b1;
`else
    localparam bit AMO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        is_atomic_mem = 1'b0;
    logic [4:0]  fun5_mem = 5'd0;
    logic [31:0] addr_mem = 32'd0;
    logic [31:0] rs2_data_mem = 32'd0;
    logic        reservation_clr = 1'b0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic        atomic_unit_stall, atomic_done, atomic_fault;
    logic [31:0] atomic_result;

    atomic_unit dut (
        .clk(clk), .reset_n(reset_n), .is_atomic_mem(is_atomic_mem), .fun5_mem(fun5_mem),
        .addr_mem(addr_mem), .rs2_data_mem(rs2_data_mem), .reservation_clr(reservation_clr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .atomic_unit_stall(atomic_unit_stall),
        .atomic_done(atomic_done), .atomic_result(atomic_result), .atomic_fault(atomic_fault)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } acc_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    acc_t        ack_q[$];
    acc_t        exp_q[$];
    int          wait_n = 0;
    bit          ref_valid = 0;
    logic [29:0] ref_addr = 30'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: programmable wait states, random rdata outside ack, stability watch
    bit          pending = 0;
    int          wcnt = 0;
    acc_t        cap;
    always @(negedge clk) begin
        if (mem_ack) begin
            if (cap.we) mem[cap.addr[9:2]] = cap.data;
            ack_q.push_back(cap);
            mem_ack = 1'b0;
            pending = 0;
        end
        mem_rdata = $urandom;
        if (mem_req) begin
            if (!pending) begin
                pending = 1;
                wcnt = 0;
                cap = '{we: mem_we, addr: mem_addr, data: mem_wdata};
            end else begin
                wcnt++;
                check("stable_we", {31'd0, mem_we}, {31'd0, cap.we});
                check("stable_addr", mem_addr, cap.addr);
                check("stable_wdata", mem_wdata, cap.data);
            end
            if (wcnt >= wait_n) begin
                mem_ack = 1'b1;
                mem_rdata = mem[mem_addr[9:2]];
            end
        end else begin
            pending = 0;
            wcnt = 0;
        end
    end

    function automatic logic [31:0] amo_ref(input logic [4:0] f, input logic [31:0] o, input logic [31:0] r);
        case (f)
            SWAP: return r;
            ADD:  return o + r;
            XOR_: return o ^ r;
            AND_: return o & r;
            OR_:  return o | r;
            MIN:  return (int'(o) < int'(r)) ? o : r;
            MAX:  return (int'(o) > int'(r)) ? o : r;
            MINU: return (o < r) ? o : r;
            default: return (o > r) ? o : r;
        endcase
    endfunction

    function automatic bit is_amo(input logic [4:0] f);
        return f inside {SWAP, ADD, XOR_, AND_, OR_, MIN, MAX, MINU, MAXU};
    endfunction

    task automatic model_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] r,
                            input bit clr, output logic [31:0] eres, output logic eflt);
        logic [31:0] old;
        exp_q.delete();
        eres = 32'd0;
        eflt = (a[1:0] != 2'b00) || !(f == LR || f == SC || (AMO_ON && is_amo(f)));
        if (eflt) begin
            if (f == SC) ref_valid = 0;
        end else if (f == LR) begin
            eres = ref_mem[a[9:2]];
            exp_q.push_back('{we: 1'b0, addr: a, data: 32'd0});
            ref_valid = 1;
            ref_addr = a[31:2];
        end else if (f == SC) begin
            if (ref_valid && ref_addr == a[31:2]) begin
                ref_mem[a[9:2]] = r;
                exp_q.push_back('{we: 1'b1, addr: a, data: r});
            end else begin
                eres = 32'd1;
            end
            ref_valid = 0;
        end else begin
            old = ref_mem[a[9:2]];
            eres = old;
            ref_mem[a[9:2]] = amo_ref(f, old, r);
            exp_q.push_back('{we: 1'b0, addr: a, data: 32'd0});
            exp_q.push_back('{we: 1'b1, addr: a, data: ref_mem[a[9:2]]});
        end
        if (clr) ref_valid = 0;
    endtask

    task automatic do_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] r,
                         input bit clr, input int w, output logic [31:0] res,
                         output logic flt, output int lat);
        bit done = 0;
        @(negedge clk); #1;
        wait_n = w;
        ack_q.delete();
        is_atomic_mem = 1'b1; fun5_mem = f; addr_mem = a; rs2_data_mem = r;
        #1 check("stall_idle", {31'd0, atomic_unit_stall}, 32'd1);
        lat = 0; res = 32'd0; flt = 1'b0;
        while (!done && lat < 60) begin
            @(negedge clk); #1;
            lat++;
            if (atomic_done) done = 1;
            else check("stall_busy", {31'd0, atomic_unit_stall}, 32'd1);
        end
        check("done_seen", {31'd0, done}, 32'd1);
        res = atomic_result;
        flt = atomic_fault;
        check("stall_done", {31'd0, atomic_unit_stall}, 32'd0);
        reservation_clr = clr;
        is_atomic_mem = 1'b0;
        @(negedge clk); #1;
        reservation_clr = 1'b0;
        check("done_pulse", {31'd0, atomic_done}, 32'd0);
    endtask

    task automatic cmp_acks(input string tag);
        check({tag, "_nacc"}, ack_q.size(), exp_q.size());
        if (ack_q.size() == exp_q.size())
            foreach (exp_q[i]) begin
                check({tag, "_we"}, {31'd0, ack_q[i].we}, {31'd0, exp_q[i].we});
                check({tag, "_addr"}, ack_q[i].addr, exp_q[i].addr);
                if (exp_q[i].we) check({tag, "_wdata"}, ack_q[i].data, exp_q[i].data);
            end
    endtask

    typedef struct {
        logic [4:0] f; logic [31:0] a; logic [31:0] r; bit clr; int w;
        logic [31:0] eres; bit eflt; int nacc; bit ewr; logic [31:0] ewd;
    } vec_t;

    initial begin
        vec_t        tbl[$];
        logic [31:0] res, mres;
        logic        flt, mflt;
        int          lat, bad;
        logic [4:0]  ops[14];
        logic [31:0] a, r;

        for (int i = 0; i < 256; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
        mem[8'h40] = 32'h11;       ref_mem[8'h40] = 32'h11;
        mem[8'h80] = 32'hFFFFFFFF; ref_mem[8'h80] = 32'hFFFFFFFF;
        mem[8'hC0] = 32'h80000000; ref_mem[8'hC0] = 32'h80000000;
        mem[8'hC1] = 32'h80000000; ref_mem[8'hC1] = 32'h80000000;

        repeat (3) @(negedge clk);
        #1;
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_done", {31'd0, atomic_done}, 32'd0);
        check("rst_fault", {31'd0, atomic_fault}, 32'd0);
        check("rst_stall", {31'd0, atomic_unit_stall}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_result", atomic_result, 32'd0);
        reset_n = 1'b1;

        tbl.push_back('{LR,   32'h100, 32'h0,  0, 1, 32'h11, 0, 1, 0, 32'h0});
        tbl.push_back('{SC,   32'h100, 32'h22, 0, 2, 32'h0,  0, 1, 1, 32'h22});
        tbl.push_back('{SC,   32'h100, 32'h33, 0, 0, 32'h1,  0, 0, 0, 32'h0});
        tbl.push_back('{ADD,  32'h200, 32'h2,  0, 3, AMO_ON ? 32'hFFFFFFFF : 32'h0, !AMO_ON, AMO_ON ? 2 : 0, AMO_ON, 32'h1});
        tbl.push_back('{MIN,  32'h300, 32'h1,  0, 0, AMO_ON ? 32'h80000000 : 32'h0, !AMO_ON, AMO_ON ? 2 : 0, AMO_ON, 32'h80000000});
        tbl.push_back('{MINU, 32'h304, 32'h1,  0, 1, AMO_ON ? 32'h80000000 : 32'h0, !AMO_ON, AMO_ON ? 2 : 0, AMO_ON, 32'h1});
        tbl.push_back('{SWAP, 32'h102, 32'h55, 0, 0, 32'h0,  1, 0, 0, 32'h0});
        tbl.push_back('{LR,   32'h100, 32'h0,  1, 0, 32'h22, 0, 1, 0, 32'h0});
        tbl.push_back('{SC,   32'h100, 32'h5,  0, 0, 32'h1,  0, 0, 0, 32'h0});
        tbl.push_back('{5'b00101, 32'h100, 32'h5, 0, 0, 32'h0, 1, 0, 0, 32'h0});
        tbl.push_back('{LR,   32'h110, 32'h0,  0, 0, 32'h0,  0, 1, 0, 32'h0});
        tbl.push_back('{SC,   32'h111, 32'h7,  0, 0, 32'h0,  1, 0, 0, 32'h0});
        tbl.push_back('{SC,   32'h110, 32'h7,  0, 0, 32'h1,  0, 0, 0, 32'h0});
        tbl.push_back('{LR,   32'h10C, 32'h0,  0, 0, 32'h0,  0, 1, 0, 32'h0});
        tbl.push_back('{SC,   32'h10C, 32'hA5A5, 0, 0, 32'h0, 0, 1, 1, 32'hA5A5});
        tbl.push_back('{SC,   32'h10C, 32'h1,  0, 0, 32'h1,  0, 0, 0, 32'h0});
        tbl.push_back('{MAXU, 32'h304, 32'hFFFFFFFF, 0, 2, AMO_ON ? 32'h1 : 32'h0, !AMO_ON, AMO_ON ? 2 : 0, AMO_ON, 32'hFFFFFFFF});
        tbl.push_back('{MAX,  32'h300, 32'h1,  0, 0, AMO_ON ? 32'h80000000 : 32'h0, !AMO_ON, AMO_ON ? 2 : 0, AMO_ON, 32'h1});

        foreach (tbl[i]) begin
            do_op(tbl[i].f, tbl[i].a, tbl[i].r, tbl[i].clr, tbl[i].w, res, flt, lat);
            model_op(tbl[i].f, tbl[i].a, tbl[i].r, tbl[i].clr, mres, mflt);
            check($sformatf("vec%0d_result", i), res, tbl[i].eres);
            check($sformatf("vec%0d_fault", i), {31'd0, flt}, {31'd0, tbl[i].eflt});
            check($sformatf("vec%0d_nacc", i), ack_q.size(), tbl[i].nacc);
            if (tbl[i].nacc == 0) check($sformatf("vec%0d_latency", i), lat, 1);
            if (tbl[i].ewr && ack_q.size() > 0) begin
                check($sformatf("vec%0d_wr_we", i), {31'd0, ack_q[ack_q.size()-1].we}, 32'd1);
                check($sformatf("vec%0d_wr_addr", i), ack_q[ack_q.size()-1].addr, tbl[i].a);
                check($sformatf("vec%0d_wr_data", i), ack_q[ack_q.size()-1].data, tbl[i].ewd);
            end
        end

        // Reset while a successful SC sits in its write wait
        do_op(LR, 32'h180, 32'h0, 0, 0, res, flt, lat);
        model_op(LR, 32'h180, 32'h0, 0, mres, mflt);
        @(negedge clk); #1;
        wait_n = 5;
        is_atomic_mem = 1'b1; fun5_mem = SC; addr_mem = 32'h180; rs2_data_mem = 32'h77;
        lat = 0;
        while (!(mem_req && mem_we) && lat < 20) begin @(negedge clk); #1; lat++; end
        check("rstw_reached_write", {31'd0, mem_req && mem_we}, 32'd1);
        reset_n = 1'b0;
        is_atomic_mem = 1'b0;
        @(negedge clk); #1;
        check("rstw_req", {31'd0, mem_req}, 32'd0);
        check("rstw_we", {31'd0, mem_we}, 32'd0);
        check("rstw_done", {31'd0, atomic_done}, 32'd0);
        check("rstw_stall", {31'd0, atomic_unit_stall}, 32'd0);
        check("rstw_result", atomic_result, 32'd0);
        reset_n = 1'b1;
        ref_valid = 0;
        do_op(SC, 32'h180, 32'h99, 0, 0, res, flt, lat);
        model_op(SC, 32'h180, 32'h99, 0, mres, mflt);
        check("rstw_sc_result", res, 32'd1);
        check("rstw_sc_nacc", ack_q.size(), 0);

        ops = '{LR, LR, SC, SC, SWAP, ADD, XOR_, AND_, OR_, MIN, MAX, MINU, MAXU, 5'b11111};
        for (int n = 0; n < 150; n++) begin
            logic [4:0] f;
            bit clr;
            f = ops[$urandom_range(0, 13)];
            a = 32'h100 + 32'($urandom_range(0, 3)) * 4;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            case ($urandom_range(0, 3))
                0: r = 32'h80000000;
                1: r = 32'h7FFFFFFF;
                default: r = $urandom;
            endcase
            clr = ($urandom_range(0, 7) == 0);
            do_op(f, a, r, clr, $urandom_range(0, 3), res, flt, lat);
            model_op(f, a, r, clr, mres, mflt);
            check($sformatf("rnd%0d_result", n), res, mres);
            check($sformatf("rnd%0d_fault", n), {31'd0, flt}, {31'd0, mflt});
            cmp_acks($sformatf("rnd%0d", n));
        end

        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("final_mem_words_differing", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
